// File: rtl/muldiv_sequencer.sv
// Iterative HI/LO unit for the MIPS EX stage: MULT/MULTU/DIV/DIVU over WIDTH+1
// cycles, MFHI/MFLO reads, MTHI/MTLO writes, and a stall for HI/LO hazards.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] mf_data
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  localparam logic [5:0] F_MFHI = 6'b010000;
  localparam logic [5:0] F_MTHI = 6'b010001;
  localparam logic [5:0] F_MFLO = 6'b010010;
  localparam logic [5:0] F_MTLO = 6'b010011;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;

  // Datapath: acc holds product (mul) or dividend/quotient in its low half (div).
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic               dz_q, dz_d;

  // Decode
  logic             is_muldiv, is_move, in_group, accept;
  logic             op_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  // Iteration and correction terms
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift, div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    is_muldiv = (funct[5:2] == 4'b0110);
    is_move   = (funct[5:2] == 4'b0100);
    in_group  = is_muldiv | is_move;
    accept    = op_valid & in_group & ~busy_q;
    stall     = op_valid & in_group & busy_q;

    op_signed = ~funct[0];
    a_neg     = op_signed & rs_data[WIDTH-1];
    b_neg     = op_signed & rt_data[WIDTH-1];
    a_mag     = a_neg ? -rs_data : rs_data;
    b_mag     = b_neg ? -rt_data : rt_data;

    mf_data = '0;
    if (op_valid && funct == F_MFHI) mf_data = hi_q;
    if (op_valid && funct == F_MFLO) mf_data = lo_q;
  end

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
    // The partial remainder is WIDTH+1 bits only transiently; after the
    // restore step it is always below the divisor and fits in WIDTH bits.
    div_shift = {rem_q, acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    prod_fix  = neg_q  ? -acc_q : acc_q;
    quo_fix   = neg_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix   = rneg_q ? -rem_q : rem_q;
  end

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_muldiv) begin
            state_d  = S_RUN;
            cnt_d    = '0;
            is_div_d = funct[1];
            neg_d    = a_neg ^ b_neg;
            rneg_d   = a_neg;
            dz_d     = funct[1] & (rt_data == '0);
            rem_d    = '0;
            if (funct[1]) begin
              acc_d  = {{WIDTH{1'b0}}, a_mag};
              opnd_d = b_mag;
            end else begin
              acc_d  = {{WIDTH{1'b0}}, b_mag};
              opnd_d = a_mag;
            end
          end else if (funct == F_MTHI) begin
            hi_d = rs_data;
          end else if (funct == F_MTLO) begin
            lo_d = rs_data;
          end
        end
      end
      S_RUN: begin
        if (is_div_q) begin
          acc_d[WIDTH-1:0] = {acc_q[WIDTH-2:0], ~div_diff[WIDTH]};
          rem_d            = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) state_d = S_FIX;
      end
      S_FIX: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = dz_q ? '1 : quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // NOTE: datapath registers are left without reset; they are always loaded
  // at accept before being read, so a reset would only cost routing.
  always_ff @(posedge clk) begin
    acc_q    <= acc_d;
    rem_q    <= rem_d;
    opnd_q   <= opnd_d;
    is_div_q <= is_div_d;
    neg_q    <= neg_d;
    rneg_q   <= rneg_d;
    dz_q     <= dz_d;
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative multiply/divide unit with its own sequencing FSM, sitting beside the ALU in the EX stage of the MIPS pipeline. It executes MULT, MULTU, DIV and DIVU over WIDTH+1 cycles into dedicated HI/LO registers. It also serves MFHI, MFLO, MTHI and MTLO. It raises a pipeline stall whenever an HI/LO-group instruction reaches EX while an operation is still in flight. The ALU keeps handling all single-cycle arithmetic; this block owns only the HI/LO group.

## Interface
- WIDTH, 32, operand width. Sets the iteration count and the HI/LO width.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- op_valid  in  1  EX holds an R-type instruction whose funct belongs to the HI/LO group.
- funct  in  6  MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011.
- rs_data  in  WIDTH  operand A (dividend or multiplicand), or the MTHI/MTLO source.
- rt_data  in  WIDTH  operand B (divisor or multiplier).
- stall  out  1  combinational; holds IF/ID/EX and inserts a bubble into MEM.
- busy  out  1  registered; an operation is in flight.
- done  out  1  registered one-cycle pulse; HI/LO were just updated by a mul/div.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- mf_data  out  WIDTH  combinational; hi for MFHI, lo for MFLO, 0 otherwise.

## Operation
- **States:**
  - IDLE: the only state in which a new instruction is accepted.
  - RUN: WIDTH iterations, counted by a log2(WIDTH)+1-bit counter.
  - FIX: one cycle for sign correction and the HI/LO write.
- **Accept:** happens in the cycle where op_valid=1, busy=0 and funct is in the group.
  - Funct values outside the group are ignored with no state change.
  - MULT/MULTU/DIV/DIVU: latch the operands and the signed/unsigned and mul/div flags, then go to RUN.
    - Signed ops latch operand magnitudes plus result-sign flags.
    - Quotient is negative when the operand signs differ. Remainder takes the sign of rs.
    - Product is negative when the operand signs differ.
  - MTHI/MTLO: write rs_data to hi or lo at the accept edge and stay in IDLE. There is no busy and no done.
  - MFHI/MFLO: pure read through mf_data, with no state change.
- **Multiply:** shift-add, one multiplier bit per RUN cycle, into a 2·WIDTH accumulator.
  - FIX: conditionally two's-complement negate the full 2·WIDTH product.
  - Then hi = upper half and lo = lower half.
- **Divide:** restoring division, one quotient bit per RUN cycle, with a WIDTH+1-bit partial remainder.
  - FIX: negate the quotient and/or remainder per their sign flags.
  - Then lo = quotient and hi = remainder.
- **Divide by zero:** detected at accept. The latency is still the full WIDTH+1 cycles.
  - lo = all ones.
  - hi = rs_data exactly as given (the signed case also returns rs unchanged).
- **Signed overflow** (most-negative / −1): lo = 0x80000000, hi = 0. This falls out of the magnitude algorithm and needs no special case.
- **Stall:**
  - stall = busy & op_valid & (funct in the group).
  - The stalled instruction is re-presented each cycle and accepted in the first cycle with busy=0.
  - hi and lo are never modified while busy except by the FIX write.
- **Reset:** while asserted, the block is forced to IDLE, the counter goes to 0, and busy, done, hi and lo all go to 0.
  - This also applies mid-RUN or mid-FIX. The aborted operation produces no done and no HI/LO write.

## Timing
- Cycle 0 is the accept cycle; the operands are sampled at its closing edge.
- RUN occupies cycles 1..WIDTH and FIX occupies cycle WIDTH+1.
- busy is 1 in cycles 1..WIDTH+1 (33 cycles for WIDTH=32) and 0 in cycle 0.
- hi/lo take their new values in cycle WIDTH+2, and done=1 in that same cycle only.
- A mul/div presented in cycle WIDTH+2 is accepted at once, so back-to-back issue costs no extra cycle. done for the old op and accept of the new op coincide legally.
- MFHI/MFLO held by stall are released in cycle WIDTH+2 and read the new hi/lo that same cycle.
- MTHI/MTLO latency is 1: the value is visible on hi/lo and mf_data in the following cycle.
- Reset values: busy=0, done=0, hi=0, lo=0, stall=0 (op_valid low), mf_data=0.

## Test plan
- MULT rs=0xFFFFFFFE, rt=3 → busy high for 33 cycles; cycle 34: done=1, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; then DIV 0x80000000/0xFFFFFFFF issued in the done cycle → accepted with no gap; hi=0, lo=0x80000000.
- DIV −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/0 → lo=0xFFFFFFFF, hi=0x00000007 after 33 busy cycles.
- MFLO presented in cycle 5 of a DIVU 100/7 → stall=1 in cycles 5..33; cycle 34: stall=0, mf_data=14; hi=2.
- MTHI 0x12345678 while idle → no busy, hi=0x12345678 next cycle; MTLO while busy → stall until done, then lo=rs_data.
- Reset asserted in cycle 10 of a MULT → next cycle busy=0, hi=lo=0, no done pulse; a new MULT 6×7 afterwards → lo=42, hi=0.
